// File: rtl/multicycle_controller.sv
// ----------------------------------------------------------------------------
// multicycle_controller
//
// Main control FSM for a multi-cycle RISC-V datapath that shares one ALU, one
// register file and one unified memory between all instruction phases.
// The FSM steps through fetch / decode / execute / memory / writeback. It
// drives the datapath mux selects, the write enables and a 2-bit aluOp code
// for the downstream ALU decoder.
//
// Supported instructions: lw, sw, R-type ALU, I-type ALU, beq and jal.
// Any other opcode, or a branch whose funct3 is not beq, parks the FSM in
// ILLEGAL. It stays there until reset.
//
// Memory handshake: mem_ready is a single-cycle "access done" strobe from
// the memory. It is sampled only in FETCH, MEMREAD and MEMWRITE. Those
// states hold while mem_ready is low and advance on the first cycle it is
// high. The FSM does not drive a request line: being in one of those states
// is the request. mem_ready is ignored in every other state.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   op         instr[6:0] from the instruction register
//   funct3     instr[14:12]; used only to validate beq
//   zero       ALU zero flag (branch condition)
//   mem_ready  memory access completes this cycle
//   PCWrite    PC register enable (PCUpdate | Branch & zero)
//   AdrSrc     memory address select: 0=PC, 1=ALUOut
//   MemWrite   memory write enable
//   IRWrite    instruction / OldPC register enable
//   RegWrite   register-file write enable
//   ResultSrc  result mux: 00=ALUOut, 01=Data, 10=ALUResult
//   ALUSrcA    ALU A mux: 00=PC, 01=OldPC, 10=rs1
//   ALUSrcB    ALU B mux: 00=rs2, 01=Imm, 10=const 4
//   aluOp      00=add, 01=sub (branch compare), 10=funct-decoded
//   ImmSrc     immediate format: 00=I, 01=S, 10=B, 11=J (from op)
//   retired    one-cycle pulse on the cycle an instruction completes
//   illegal    sticky flag: an unsupported instruction was decoded
//   state_dbg  current FSM state (encoding listed in state_t)
// ----------------------------------------------------------------------------
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         aluOp,
  output logic [1:0]         ImmSrc,
  output logic               retired,
  output logic               illegal,
  output logic [STATE_W-1:0] state_dbg
);

  // Opcodes
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] F3_BEQ = 3'b000;

  // Fixed state encoding. The debug output exposes these values.
  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECR    = STATE_W'(6),
    EXECI    = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    BEQ      = STATE_W'(9),
    JAL      = STATE_W'(10),
    ILLEGAL  = STATE_W'(15)
  } state_t;

  state_t state;

  // Set while ALUWB is the link-register write of a jal. The jal already
  // reported its retirement in the JAL state, so ALUWB must not pulse again.
  logic from_jal;

  logic pc_update;
  logic branch;

  assign state_dbg = state;

  // --------------------------------------------------------------------------
  // State register, sticky illegal flag and the jal-origin flag.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      illegal  <= 1'b0;
      from_jal <= 1'b0;
    end else begin
      from_jal <= (state == JAL);
      case (state)
        FETCH: begin
          if (mem_ready) state <= DECODE;
        end

        DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= MEMADR;
            OP_R:         state <= EXECR;
            OP_I:         state <= EXECI;
            OP_BR: begin
              if (funct3 == F3_BEQ) begin
                state <= BEQ;
              end else begin
                state   <= ILLEGAL;
                illegal <= 1'b1;
              end
            end
            OP_JAL:       state <= JAL;
            default: begin
              state   <= ILLEGAL;
              illegal <= 1'b1;
            end
          endcase
        end

        // Only lw and sw reach MEMADR. op is held in the IR, so it still
        // identifies the access type here.
        MEMADR: begin
          state <= (op == OP_SW) ? MEMWRITE : MEMREAD;
        end

        MEMREAD: begin
          if (mem_ready) state <= MEMWB;
        end

        MEMWB:    state <= FETCH;

        MEMWRITE: begin
          if (mem_ready) state <= FETCH;
        end

        EXECR:    state <= ALUWB;
        EXECI:    state <= ALUWB;
        ALUWB:    state <= FETCH;
        BEQ:      state <= FETCH;

        // jal redirects the PC here, then writes rd = OldPC + 4 in ALUWB.
        JAL:      state <= ALUWB;

        ILLEGAL: begin
          state   <= ILLEGAL;
          illegal <= 1'b1;
        end

        // Unused encodings restart cleanly at the next fetch.
        default:  state <= FETCH;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output decode. The selects follow the state. The enables also depend on
  // mem_ready (FETCH, MEMWRITE) and on zero (branch).
  // --------------------------------------------------------------------------
  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    aluOp     = 2'b00;
    retired   = 1'b0;

    case (state)
      // PC + 4 goes straight from the ALU result into the PC. The IR and
      // the PC are written together when the memory returns the word.
      FETCH: begin
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        pc_update = mem_ready;
      end

      // The ALU speculatively computes the branch target OldPC + Imm.
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end

      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end

      MEMREAD: begin
        AdrSrc = 1'b1;
      end

      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        retired   = 1'b1;
      end

      // The write strobe stays up for the whole access. The store retires
      // on the cycle the memory accepts it.
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        retired  = mem_ready;
      end

      EXECR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b00;
        aluOp   = 2'b10;
      end

      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluOp   = 2'b10;
      end

      ALUWB: begin
        ResultSrc = 2'b00;
        RegWrite  = 1'b1;
        retired   = ~from_jal;
      end

      // rs1 - rs2 sets zero. ALUOut still holds the target from DECODE.
      BEQ: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b00;
        aluOp     = 2'b01;
        ResultSrc = 2'b00;
        branch    = 1'b1;
        retired   = 1'b1;
      end

      // The PC takes the target held in ALUOut. The ALU meanwhile forms
      // OldPC + 4 for the link register.
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        aluOp     = 2'b00;
        ResultSrc = 2'b00;
        pc_update = 1'b1;
        retired   = 1'b1;
      end

      default: ;
    endcase

    PCWrite = pc_update | (branch & zero);

    // Reset forces the state to FETCH asynchronously, so the selects
    // already show FETCH values. The enables are also held low so no
    // register or memory location is written while reset is asserted.
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      retired  = 1'b0;
    end
  end

  // Immediate format depends only on the opcode in the IR.
  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule
